tick_gen: RTL and testbench

- Parametrised successor to the free-running divider. Produces a registered one-cycle `tick` enable pulse at one of NUM_SPEEDS power-of-two periods.
- Adds run/pause, single-step, glitch-free speed change, a square-wave output and a tick counter.
- Sits between the board switches/buttons and the simulation-update logic. Downstream logic uses `tick` as a clock enable and never as a clock.

---
 rtl/tick_gen.sv | 151 +++++++++++++++
 tb/tb_tick_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// tick_gen: power-of-two tick enable generator with run/pause, single-step and
// glitch-free speed change. Define TICK_GEN_SYNC_EN to add 2-flop input synchronisers.
module tick_gen #(
   parameter int unsigned NUM_SPEEDS = 4,
   parameter int unsigned SLOW_SHIFT = 25,
   parameter int unsigned STEP_SHIFT = 1,
   parameter int unsigned CNT_W      = SLOW_SHIFT + 1,
   parameter int unsigned TCNT_W     = 16,
   localparam int unsigned SPD_W     = $clog2(NUM_SPEEDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [SPD_W-1:0]  speed_sel,
   input  logic              step,
   output logic              tick,
   output logic              tick_sq,
   output logic [TCNT_W-1:0] tick_count,
   output logic              running
);

   generate
      if (NUM_SPEEDS < 2) begin : g_chk_num
         $error("tick_gen: NUM_SPEEDS must be at least 2");
      end
      if (SLOW_SHIFT < (NUM_SPEEDS - 1) * STEP_SHIFT) begin : g_chk_shift
         $error("tick_gen: SLOW_SHIFT too small for NUM_SPEEDS/STEP_SHIFT");
      end
   endgenerate

   typedef enum logic {
      S_PAUSE = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   logic              w_en;
   logic              w_step;
   logic [SPD_W-1:0]  w_speed_in;
   logic [SPD_W-1:0]  w_sel;
   logic [CNT_W-1:0]  w_last;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [SPD_W-1:0]  r_active_sel;
   logic              r_step_d;
   logic              r_tick;
   logic              r_tick_sq;
   logic [TCNT_W-1:0] r_tick_count;
   logic              r_running;

`ifdef TICK_GEN_SYNC_EN
   logic [1:0]        r_en_sync;
   logic [1:0]        r_step_sync;
   logic [SPD_W-1:0]  r_sel_sync0;
   logic [SPD_W-1:0]  r_sel_sync1;

   // step synchroniser resets high so a held button cannot fake a rising edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en_sync   <= '0;
         r_step_sync <= '1;
         r_sel_sync0 <= '0;
         r_sel_sync1 <= '0;
      end else begin
         r_en_sync   <= {r_en_sync[0], en};
         r_step_sync <= {r_step_sync[0], step};
         r_sel_sync0 <= speed_sel;
         r_sel_sync1 <= r_sel_sync0;
      end
   end

   assign w_en       = r_en_sync[1];
   assign w_step     = r_step_sync[1];
   assign w_speed_in = r_sel_sync1;
`else
   assign w_en       = en;
   assign w_step     = step;
   assign w_speed_in = speed_sel;
`endif

   assign w_sel = (w_speed_in > SPD_W'(NUM_SPEEDS - 1)) ? SPD_W'(NUM_SPEEDS - 1) : w_speed_in;

   function automatic logic [CNT_W-1:0] f_last(input int unsigned k);
      f_last = (CNT_W'(1) << (SLOW_SHIFT - k * STEP_SHIFT)) - CNT_W'(1);
   endfunction

   // terminal count per speed is a constant; only the mux is built in hardware
   always_comb begin
      w_last = '0;
      for (int unsigned k = 0; k < NUM_SPEEDS; k++) begin
         if (r_active_sel == SPD_W'(k)) w_last = f_last(k);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_PAUSE;
         r_cnt        <= '0;
         r_active_sel <= '0;
         r_step_d     <= 1'b1;
         r_tick       <= 1'b0;
         r_tick_sq    <= 1'b0;
         r_tick_count <= '0;
         r_running    <= 1'b0;
      end else begin
         r_step_d <= w_step;
         if (r_tick) begin
            r_tick_sq    <= ~r_tick_sq;
            r_tick_count <= r_tick_count + TCNT_W'(1);
         end
         case (r_state)
            S_PAUSE: begin
               r_cnt        <= '0;
               r_active_sel <= w_sel;
               r_tick       <= w_step & ~r_step_d;
               if (w_en) begin
                  r_state   <= S_RUN;
                  r_running <= 1'b1;
               end
            end
            S_RUN: begin
               if (!w_en) begin
                  r_state   <= S_PAUSE;
                  r_running <= 1'b0;
                  r_cnt     <= '0;
                  r_tick    <= 1'b0;
               end else if (r_cnt == w_last) begin
                  r_cnt        <= '0;
                  r_tick       <= 1'b1;
                  r_active_sel <= w_sel;
               end else begin
                  r_cnt  <= r_cnt + CNT_W'(1);
                  r_tick <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_PAUSE;
               r_running <= 1'b0;
               r_cnt     <= '0;
               r_tick    <= 1'b0;
            end
         endcase
      end
   end

   assign tick       = r_tick;
   assign tick_sq    = r_tick_sq;
   assign tick_count = r_tick_count;
   assign running    = r_running;

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed checks of tick_gen at SLOW_SHIFT=4 (periods 16/8/4/2),
// plus a 3-speed narrow-counter instance for clamp and tick_count wrap.
module tb_tick_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        step;
   logic [1:0]  speed_sel;
   logic        tick;
   logic        tick_sq;
   logic [15:0] tick_count;
   logic        running;

   logic        en2;
   logic        step2;
   logic [1:0]  sel2;
   logic        tick2;
   logic        sq2;
   logic [7:0]  cnt2;
   logic        running2;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   tick_gen #(
      .NUM_SPEEDS (4),
      .SLOW_SHIFT (4),
      .STEP_SHIFT (1),
      .TCNT_W     (16)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .speed_sel  (speed_sel),
      .step       (step),
      .tick       (tick),
      .tick_sq    (tick_sq),
      .tick_count (tick_count),
      .running    (running)
   );

   tick_gen #(
      .NUM_SPEEDS (3),
      .SLOW_SHIFT (4),
      .STEP_SHIFT (1),
      .TCNT_W     (8)
   ) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .en         (en2),
      .speed_sel  (sel2),
      .step       (step2),
      .tick       (tick2),
      .tick_sq    (sq2),
      .tick_count (cnt2),
      .running    (running2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int unsigned ntk;
      int unsigned mism;
      int unsigned first;
      logic        exp_t;

      rst = 1'b1; en = 1'b0; step = 1'b1; speed_sel = 2'd0;
      en2 = 1'b0; step2 = 1'b0; sel2 = 2'd0;
      cyc(3);
      chk("rst_tick",    32'(tick), 32'd0);
      chk("rst_sq",      32'(tick_sq), 32'd0);
      chk("rst_count",   32'(tick_count), 32'd0);
      chk("rst_running", 32'(running), 32'd0);

      // step held high across reset release must not tick
      rst = 1'b0;
      ntk = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         ntk += 32'(tick);
      end
      chk("step_held_rst", ntk, 0);
      step = 1'b0;
      cyc(1);

      // speed 0: first tick after edge 17, then every 16
      en = 1'b1; speed_sel = 2'd0;
      mism = 0; ntk = 0; first = 0;
      for (int i = 1; i <= 100; i++) begin
         cyc(1);
         exp_t = (i >= 17) && (((i - 17) % 16) == 0);
         if (tick !== exp_t) mism++;
         if (tick) begin
            ntk++;
            if (first == 0) first = 32'(i);
         end
      end
      chk("spd0_first",   first, 17);
      chk("spd0_ticks",   ntk, 6);
      chk("spd0_pattern", mism, 0);
      chk("spd0_count",   32'(tick_count), 32'd6);
      chk("spd0_sq",      32'(tick_sq), 32'd0);
      chk("spd0_running", 32'(running), 32'd1);

      // cnt is 3 now; advance to 5 then request speed 3
      cyc(2);
      speed_sel = 2'd3;
      mism = 0;
      for (int i = 1; i <= 18; i++) begin
         cyc(1);
         exp_t = (i >= 11) && ((i % 2) == 1);
         if (tick !== exp_t) mism++;
      end
      chk("spdchg_pattern", mism, 0);
      chk("spdchg_count",   32'(tick_count), 32'd10);

      // back to speed 0 at the next wrap, then drop en when cnt==15
      speed_sel = 2'd0;
      cyc(1);
      chk("wrap_p2_tick", 32'(tick), 32'd1);
      ntk = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         ntk += 32'(tick);
      end
      chk("p16_no_tick", ntk, 0);
      en = 1'b0;
      cyc(1);
      chk("pause_wrap_tick",    32'(tick), 32'd0);
      chk("pause_wrap_running", 32'(running), 32'd0);
      chk("pause_wrap_count",   32'(tick_count), 32'd11);

      en = 1'b1;
      mism = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         exp_t = (i == 17);
         if (tick !== exp_t) mism++;
      end
      chk("resume_pattern", mism, 0);
      chk("resume_count",   32'(tick_count), 32'd12);

      // single step while paused
      en = 1'b0;
      cyc(1);
      chk("step_paused_running", 32'(running), 32'd0);
      ntk = 0;
      for (int i = 0; i < 12; i++) begin
         step = ((i % 4) == 0);
         cyc(1);
         ntk += 32'(tick);
      end
      chk("step3_ticks", ntk, 3);
      step = 1'b0;
      cyc(2);
      chk("step3_count", 32'(tick_count), 32'd15);

      step = 1'b1;
      ntk = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         ntk += 32'(tick);
      end
      step = 1'b0;
      cyc(1);
      ntk += 32'(tick);
      chk("step_level_ticks", ntk, 1);
      chk("step_level_count", 32'(tick_count), 32'd16);

      // step is ignored while running
      en = 1'b1;
      ntk = 0;
      for (int i = 0; i < 10; i++) begin
         step = ((i % 2) == 1);
         cyc(1);
         ntk += 32'(tick);
      end
      chk("step_in_run_ticks", ntk, 0);
      chk("step_in_run_running", 32'(running), 32'd1);

      // asynchronous reset mid-period takes effect before the next edge
      step = 1'b0;
      cyc(3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_running", 32'(running), 32'd0);
      chk("async_rst_count",   32'(tick_count), 32'd0);
      en = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(1);

      // 3-speed instance: speed_sel=3 clamps to speed 2 (period 4), 8-bit count wraps
      en2 = 1'b1; sel2 = 2'd3;
      mism = 0;
      for (int i = 1; i <= 1025; i++) begin
         cyc(1);
         exp_t = (i >= 5) && (((i - 5) % 4) == 0);
         if (tick2 !== exp_t) mism++;
      end
      chk("clamp_pattern",   mism, 0);
      chk("clamp_tick_last", 32'(tick2), 32'd1);
      chk("clamp_cnt_255",   32'(cnt2), 32'd255);
      chk("clamp_sq_odd",    32'(sq2), 32'd1);
      cyc(1);
      chk("wrap_cnt_0",      32'(cnt2), 32'd0);
      chk("wrap_sq",         32'(sq2), 32'd0);
      chk("wrap_running",    32'(running2), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
